// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
// Saturates values above 9999 to 16'h9999 and flags overflow.
module bin_to_bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [15:0]      bcd_out
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [BIN_W-1:0] shreg;
  logic [15:0]      scratch;
  logic [15:0]      adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (cnt == LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All four digits corrected from the pre-shift value; carry out dropped.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= 16'h0000;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin_in;
            scratch  <= '0;
            cnt      <= '0;
            ovf_next <= 32'(bin_in) > 32'd9999;
          end
        end
        CONVERT: begin
          scratch <= {adj[14:0], shreg[BIN_W-1]};
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
        end
        FINISH: begin
          bcd_out <= ovf_next ? 16'h9999 : scratch;
          ovf     <= ovf_next;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, corner
// sequences and random values against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.BIN_W(14)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    model = {v > 9999,
             4'((s / 1000) % 10), 4'((s / 100) % 10),
             4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic run(input logic [13:0] v, input logic [15:0] eb,
                     input logic eo, input string nm);
    logic [15:0] prev;
    logic        bad;
    int          cyc;
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    prev = bcd_out;
    @(negedge clk);
    start = 1'b0;
    bin_in = 14'($urandom);
    cyc = 0;
    bad = 1'b0;
    while (!done && cyc < 40) begin
      if (!busy || bcd_out !== prev) bad = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk({nm, "_busy_hold"}, 32'(bad), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(cyc), 32'd15);
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, "_bcd"}, 32'(bcd_out), 32'(eb));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    vec_t        vt[10];
    logic [16:0] m;
    logic [13:0] r;
    int          cyc;
    int          n;

    vt[0] = '{14'd1234,  16'h1234, 1'b0};
    vt[1] = '{14'd0,     16'h0000, 1'b0};
    vt[2] = '{14'd9,     16'h0009, 1'b0};
    vt[3] = '{14'd10,    16'h0010, 1'b0};
    vt[4] = '{14'd99,    16'h0099, 1'b0};
    vt[5] = '{14'd100,   16'h0100, 1'b0};
    vt[6] = '{14'd9999,  16'h9999, 1'b0};
    vt[7] = '{14'd10000, 16'h9999, 1'b1};
    vt[8] = '{14'd16383, 16'h9999, 1'b1};
    vt[9] = '{14'd42,    16'h0042, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);

    foreach (vt[i])
      run(vt[i].bin, vt[i].bcd, vt[i].ovf, $sformatf("vec%0d", i));

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1;
    bin_in = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin_in = 14'd1111;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", cyc);
    chk("ign_bcd", 32'(bcd_out), 32'h5678);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("ign_no_second", 32'(n), 32'd0);
    chk("ign_bcd_hold", 32'(bcd_out), 32'h5678);

    // reset mid-conversion aborts with no done
    @(negedge clk);
    start = 1'b1;
    bin_in = 14'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bcd", 32'(bcd_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    run(14'd4321, 16'h4321, 1'b0, "after_abort");

    // held start: back-to-back, one result every 16 cycles
    @(negedge clk);
    start = 1'b1;
    bin_in = 14'd777;
    wait_done("b2b_first", cyc);
    @(negedge clk);
    wait_done("b2b_second", cyc);
    start = 1'b0;
    chk("b2b_period", 32'(cyc + 1), 32'd16);
    chk("b2b_bcd", 32'(bcd_out), 32'h0777);
    repeat (20) @(negedge clk);

    for (int k = 0; k < 30; k++) begin
      r = (k % 5 == 4) ? 14'($urandom_range(10000, 16383))
                       : 14'($urandom_range(0, 9999));
      m = model(int'(r));
      run(r, m[15:0], m[16], $sformatf("rnd%0d_%0d", k, r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
